pkt_length_checksum_meta: RTL
=============================

// Module: pkt_length_checksum_meta
// PURPOSE
//  Next-generation length/checksum calculator for the NMU egress path. It passes an AXI-Stream
//  through with zero latency and keeps a running byte count and 16-bit one's-complement sum.
//  The sum starts at a programmable byte offset. A {length, checksum, overflow} record is
//  pushed into a metadata FIFO at every tlast, so encap can consume per-packet results later.
//  The stream stalls on tlast when the FIFO is full.
// PARAMETERS
//  AXIS_BUS_WIDTH    64  data width in bits, power of 2, 16..512
//  AXIS_TUSER_WIDTH  4   tuser width, passed through untouched
//  CSUM_START_BYTE   0   packet byte offset where checksumming begins (0..65535)
//  META_FIFO_DEPTH   4   metadata records buffered, power of 2, >=2
//  CSUM_INVERT       0   1: record holds ~sum (final IP/UDP form); 0: raw sum
//  COUNT_LENGTH      1   0: length field tied to 0, counter logic removed
//  CALC_CHECKSUM     1   0: checksum field tied to 0, adder tree removed
// PORTS
//  aclk             in   1     clock
//  aresetn          in   1     asynchronous active-low reset
//  axis_in_tdata    in   W     input data
//  axis_in_tuser    in   U     input user
//  axis_in_tkeep    in   W/8   byte enables; contiguous from lane 0, partial only on tlast
//  axis_in_tlast    in   1     end of packet
//  axis_in_tvalid   in   1     input valid
//  axis_in_tready   out  1     input ready
//  axis_out_t*      out  —     tdata/tuser/tkeep/tlast/tvalid mirror inputs; axis_out_tready in
//  meta_tdata       out  33    {overflow[32], checksum[31:16], length[15:0]}
//  meta_tvalid      out  1     FIFO not empty
//  meta_tready      in   1     pop FIFO head
//  meta_count       out  log2(D)+1  records held
// BEHAVIOUR
//  Clock, reset and FIFO
//  - Single clock aclk. Reset is asynchronous and active-low on aresetn.
//  - All state is in always @(posedge aclk or negedge aresetn).
//  - Reset clears the byte counter, beat counter, sum, overflow flag and FIFO pointers.
//    After reset: meta_tvalid=0, meta_count=0, meta_tdata=0.
//  - A reset mid-packet discards the partial packet. No record is written for it.
//  Stream handshake
//  - stall = axis_in_tlast && fifo_full.
//  - axis_out_tvalid = axis_in_tvalid && !stall.
//  - axis_in_tready = axis_out_tready && !stall.
//  - Data, tuser, tkeep and tlast are combinational passthrough (latency 0).
//  - beat = axis_in_tvalid && axis_in_tready.
//  Length
//  - Beat byte count = NUM_BUS_BYTES on non-last beats.
//  - On tlast it is the index of the first 0 in tkeep (0..NUM_BUS_BYTES).
//  - The length counter saturates at 16'hFFFF and sets a sticky overflow bit for the packet.
//  Checksum
//  - Byte b (absolute packet offset) is included only if tkeep is set and b >= CSUM_START_BYTE.
//  - Even b goes to bits [15:8] of its 16-bit word, odd b to bits [7:0].
//  - Absolute offset = beat_count*NUM_BUS_BYTES + lane. The beat counter is 16 bits and saturates.
//  - Lanes are reduced by a log2(lanes) adder tree with end-around carry at every stage.
//  - The tree result is added to the accumulator with end-around carry.
//  FIFO push and pop
//  - On a tlast beat the record built from the final sum and length is written to the FIFO.
//  - In the same edge, the accumulators and beat counter clear to 0.
//  - If CSUM_INVERT=1 the stored checksum is ~sum.
//  - Push and pop in the same cycle keeps meta_count unchanged; allowed when not full.
//  - full/empty come from the registered count. A pop in the same cycle does not unblock a
//    stalled tlast; the push waits one cycle.
//  - Record order equals packet order. meta_tdata shows the FIFO head and holds until popped.
//  - A single-beat packet (tlast on the first beat) produces a correct record.
//  - A zero-byte beat (tkeep=0 with tlast) adds 0 bytes and a 0 sum.
// STRUCTURE
//  - Shared package nmu_meta_pkg:
//    - typedef struct packed {logic ovf; logic [15:0] csum; logic [15:0] len;} pkt_meta_t.
//    - function oc_add16 (one's-complement add with end-around carry).
//    - localparam META_W = 33.
//  - Sub-module sync_meta_fifo: parameters DEPTH and WIDTH; ports aclk, aresetn, push, pop,
//    din, dout, full, empty, count. Storage is a register array with async-reset pointers.
//  - The top level holds the counters, lane masking, adder tree and handshake logic.
// TESTING
//  1. 64-bit bus, one 3-beat packet, 20 bytes (last tkeep=8'h0F).
//     -> record len=20, csum = RFC1071 sum of the bytes; meta_tvalid rises the cycle after tlast.
//  2. CSUM_START_BYTE=14, 34-byte packet (14B Ethernet hdr + 20B IPv4 hdr, checksum field 0).
//     -> CSUM_INVERT=1 record equals the known IPv4 header checksum 16'hB1E6
//        for the RFC reference header.
//  3. Data 16'hFFFF repeated 8 times.
//     -> sum stays 16'hFFFF (end-around carry), never wraps to 0.
//  4. META_FIFO_DEPTH=2, meta_tready=0, send 3 packets.
//     -> third tlast sees axis_in_tready=0 and axis_out_tvalid=0.
//     -> pop one record: stall clears the next cycle and the third record is stored; meta_count=2.
//  5. Packet of 70000 bytes.
//     -> len=16'hFFFF and ovf=1; the next packet's record has ovf=0.
//  6. Assert aresetn low mid-packet (asynchronously, between edges).
//     -> meta_tvalid=0 immediately. The next packet's record covers only post-reset bytes.

Source files
------------

// File: rtl/nmu_meta_pkg.sv
// Shared types and helpers for the NMU egress length/checksum metadata path.
package nmu_meta_pkg;

  localparam int unsigned META_W = 33;

  typedef struct packed {
    logic        ovf;
    logic [15:0] csum;
    logic [15:0] len;
  } pkt_meta_t;

  // One's-complement add: a carry out of bit 15 wraps back into bit 0.
  function automatic logic [15:0] oc_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'b0, s[16]};
  endfunction

endpackage

// File: rtl/sync_meta_fifo.sv
// Single-clock FIFO for per-packet metadata records; flags derive from the registered count.
module sync_meta_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 33
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q, count_d;
  logic              wr_en, rd_en;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign wr_en = push & ~full;
  assign rd_en = pop & ~empty;
  // Head reads as zero while empty so the output is clean after reset.
  assign dout  = empty ? '0 : mem[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (wr_en) mem[wr_ptr_q] <= din;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pkt_length_checksum_meta.sv
// Zero-latency AXI-Stream tap computing per-packet length and one's-complement sum,
// queueing one metadata record per packet.
module pkt_length_checksum_meta
  import nmu_meta_pkg::*;
#(
  parameter int unsigned AXIS_BUS_WIDTH   = 64,
  parameter int unsigned AXIS_TUSER_WIDTH = 4,
  parameter int unsigned CSUM_START_BYTE  = 0,
  parameter int unsigned META_FIFO_DEPTH  = 4,
  parameter int unsigned CSUM_INVERT      = 0,
  parameter int unsigned COUNT_LENGTH     = 1,
  parameter int unsigned CALC_CHECKSUM    = 1
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic [AXIS_BUS_WIDTH-1:0]         axis_in_tdata,
  input  logic [AXIS_TUSER_WIDTH-1:0]       axis_in_tuser,
  input  logic [AXIS_BUS_WIDTH/8-1:0]       axis_in_tkeep,
  input  logic                              axis_in_tlast,
  input  logic                              axis_in_tvalid,
  output logic                              axis_in_tready,
  output logic [AXIS_BUS_WIDTH-1:0]         axis_out_tdata,
  output logic [AXIS_TUSER_WIDTH-1:0]       axis_out_tuser,
  output logic [AXIS_BUS_WIDTH/8-1:0]       axis_out_tkeep,
  output logic                              axis_out_tlast,
  output logic                              axis_out_tvalid,
  input  logic                              axis_out_tready,
  output logic [META_W-1:0]                 meta_tdata,
  output logic                              meta_tvalid,
  input  logic                              meta_tready,
  output logic [$clog2(META_FIFO_DEPTH):0]  meta_count
);

  localparam int unsigned NUM_BUS_BYTES = AXIS_BUS_WIDTH / 8;
  localparam int unsigned NUM_WORDS     = AXIS_BUS_WIDTH / 16;
  localparam int unsigned BCW           = $clog2(NUM_BUS_BYTES + 1);

  logic        fifo_full, fifo_empty;
  logic        stall, beat, push, pop;
  logic [15:0] len_next;
  logic        ovf_next;
  logic [15:0] csum_rec;
  pkt_meta_t   rec;

  assign stall           = axis_in_tlast & fifo_full;
  assign axis_out_tvalid = axis_in_tvalid & ~stall;
  assign axis_in_tready  = axis_out_tready & ~stall;
  assign axis_out_tdata  = axis_in_tdata;
  assign axis_out_tuser  = axis_in_tuser;
  assign axis_out_tkeep  = axis_in_tkeep;
  assign axis_out_tlast  = axis_in_tlast;

  assign beat = axis_in_tvalid & axis_in_tready;
  assign push = beat & axis_in_tlast;
  assign pop  = meta_tready & meta_tvalid;

  if (COUNT_LENGTH != 0) begin : g_len
    logic [BCW-1:0] beat_bytes;
    logic [16:0]    len_sum;
    logic [15:0]    len_q;
    logic           ovf_q;

    // tkeep is contiguous from lane 0, so the first clear lane is the byte count.
    always_comb begin
      beat_bytes = BCW'(NUM_BUS_BYTES);
      if (axis_in_tlast) begin
        for (int i = NUM_BUS_BYTES - 1; i >= 0; i--) begin
          if (!axis_in_tkeep[i]) beat_bytes = BCW'(i);
        end
      end
    end

    assign len_sum  = {1'b0, len_q} + 17'(beat_bytes);
    assign len_next = len_sum[16] ? 16'hFFFF : len_sum[15:0];
    assign ovf_next = ovf_q | len_sum[16];

    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
        len_q <= '0;
        ovf_q <= 1'b0;
      end else if (beat) begin
        len_q <= axis_in_tlast ? 16'h0 : len_next;
        ovf_q <= axis_in_tlast ? 1'b0 : ovf_next;
      end
    end
  end else begin : g_no_len
    assign len_next = '0;
    assign ovf_next = 1'b0;
  end

  if (CALC_CHECKSUM != 0) begin : g_csum
    logic [NUM_BUS_BYTES-1:0] byte_en;
    logic [15:0]              words [NUM_WORDS];
    logic [15:0]              tree_sum, sum_next, sum_q, beat_cnt_q;
    logic [31:0]              base;

    assign base = 32'(beat_cnt_q) * NUM_BUS_BYTES;

    // Lane pairs form big-endian 16-bit words, then a pairwise tree folds them.
    always_comb begin
      byte_en = '0;
      for (int i = 0; i < NUM_BUS_BYTES; i++) begin
        byte_en[i] = axis_in_tkeep[i] && ((base + 32'(i)) >= CSUM_START_BYTE);
      end
      for (int k = 0; k < NUM_WORDS; k++) begin
        words[k] = {byte_en[2*k]   ? axis_in_tdata[16*k +: 8]   : 8'h00,
                    byte_en[2*k+1] ? axis_in_tdata[16*k+8 +: 8] : 8'h00};
      end
      for (int s = 1; s < NUM_WORDS; s = s * 2) begin
        for (int k = 0; k < NUM_WORDS; k = k + 2 * s) begin
          words[k] = oc_add16(words[k], words[k+s]);
        end
      end
      tree_sum = words[0];
    end

    assign sum_next = oc_add16(sum_q, tree_sum);
    assign csum_rec = (CSUM_INVERT != 0) ? ~sum_next : sum_next;

    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
        sum_q      <= '0;
        beat_cnt_q <= '0;
      end else if (beat) begin
        if (axis_in_tlast) begin
          sum_q      <= '0;
          beat_cnt_q <= '0;
        end else begin
          sum_q      <= sum_next;
          beat_cnt_q <= (beat_cnt_q == 16'hFFFF) ? beat_cnt_q : beat_cnt_q + 16'd1;
        end
      end
    end
  end else begin : g_no_csum
    assign csum_rec = '0;
  end

  always_comb begin
    rec      = '0;
    rec.len  = len_next;
    rec.csum = csum_rec;
    rec.ovf  = ovf_next;
  end

  assign meta_tvalid = ~fifo_empty;

  sync_meta_fifo #(
    .DEPTH (META_FIFO_DEPTH),
    .WIDTH (META_W)
  ) u_meta_fifo (
    .aclk    (aclk),
    .aresetn (aresetn),
    .push    (push),
    .pop     (pop),
    .din     (rec),
    .dout    (meta_tdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (meta_count)
  );

endmodule
